// File: rtl/four_bit_cpu.sv
// -----------------------------------------------------------------------------
// four_bit_cpu
// Accumulator machine with a unified 2**n x 8 program/data memory.  Every
// instruction is fetched, decoded and retired in a single clock because the
// memory is read combinationally.  While rst is high the CPU is held in reset
// and program words are streamed into memory from address 0 upward.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : synchronous active-high reset, doubles as program-load enable
//   myprogram  : program word stored at the load pointer while rst=1
//   myinput    : external data sampled by the IN instruction
//   myoutput   : registered output port, written by OUT
//   HLT        : registered, 1 once a HLT instruction has retired
//   s_flag     : registered sign flag (bit 7 of last flag-setting result)
//   z_flag     : registered zero flag
//   c_flag     : registered carry / borrow flag
//
// The 4-bit operand field addresses memory, so n is expected to stay at 4.
// -----------------------------------------------------------------------------
module four_bit_cpu #(
    parameter int n = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] myprogram,
    input  logic [7:0] myinput,
    output logic [7:0] myoutput,
    output logic       HLT,
    output logic       s_flag,
    output logic       z_flag,
    output logic       c_flag
);

    localparam int DEPTH = 2 ** n;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDA = 4'h1, OP_LDI = 4'h2, OP_ADD = 4'h3,
        OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
        OP_STA = 4'h8, OP_IN  = 4'h9, OP_OUT = 4'hA, OP_JMP = 4'hB,
        OP_JZ  = 4'hC, OP_JC  = 4'hD, OP_JS  = 4'hE, OP_HLT = 4'hF
    } opcode_t;

    logic [7:0]   r_mem [DEPTH];
    logic [7:0]   r_acc;
    logic [n-1:0] r_pc;
    logic [n-1:0] r_lp;

    logic [7:0]   w_instr;
    opcode_t      w_op;
    logic [n-1:0] w_addr;
    logic [7:0]   w_opnd;
    logic [8:0]   w_sum;
    logic [8:0]   w_diff;
    logic [7:0]   w_acc_nxt;
    logic [n-1:0] w_pc_nxt;
    logic         w_c_nxt;
    logic         w_zs_upd;
    logic         w_z_nxt;
    logic         w_s_nxt;
    logic         w_mem_we;
    logic         w_out_we;
    logic         w_halt_nxt;

    assign w_instr = r_mem[r_pc];
    assign w_op    = opcode_t'(w_instr[7:4]);
    assign w_addr  = w_instr[n-1:0];
    assign w_opnd  = r_mem[w_addr];
    assign w_sum   = {1'b0, r_acc} + {1'b0, w_opnd};
    // Bit 8 of the 9-bit difference is the unsigned borrow (A < M[k]).
    assign w_diff  = {1'b0, r_acc} - {1'b0, w_opnd};

    // Decode the current instruction into next-state values.
    always_comb begin
        w_acc_nxt  = r_acc;
        w_pc_nxt   = r_pc + n'(1);
        w_c_nxt    = c_flag;
        w_zs_upd   = 1'b0;
        w_mem_we   = 1'b0;
        w_out_we   = 1'b0;
        w_halt_nxt = 1'b0;
        case (w_op)
            OP_NOP: w_acc_nxt = r_acc;
            OP_LDA: begin w_acc_nxt = w_opnd;              w_zs_upd = 1'b1; end
            OP_LDI: begin w_acc_nxt = {4'h0, w_instr[3:0]}; w_zs_upd = 1'b1; end
            OP_ADD: begin
                w_acc_nxt = w_sum[7:0];
                w_c_nxt   = w_sum[8];
                w_zs_upd  = 1'b1;
            end
            OP_SUB: begin
                w_acc_nxt = w_diff[7:0];
                w_c_nxt   = w_diff[8];
                w_zs_upd  = 1'b1;
            end
            OP_AND: begin w_acc_nxt = r_acc & w_opnd; w_c_nxt = 1'b0; w_zs_upd = 1'b1; end
            OP_OR:  begin w_acc_nxt = r_acc | w_opnd; w_c_nxt = 1'b0; w_zs_upd = 1'b1; end
            OP_XOR: begin w_acc_nxt = r_acc ^ w_opnd; w_c_nxt = 1'b0; w_zs_upd = 1'b1; end
            OP_STA: w_mem_we = 1'b1;
            OP_IN:  begin w_acc_nxt = myinput; w_zs_upd = 1'b1; end
            OP_OUT: w_out_we = 1'b1;
            OP_JMP: w_pc_nxt = w_addr;
            OP_JZ:  if (z_flag) w_pc_nxt = w_addr; else w_pc_nxt = r_pc + n'(1);
            OP_JC:  if (c_flag) w_pc_nxt = w_addr; else w_pc_nxt = r_pc + n'(1);
            OP_JS:  if (s_flag) w_pc_nxt = w_addr; else w_pc_nxt = r_pc + n'(1);
            OP_HLT: begin w_pc_nxt = r_pc; w_halt_nxt = 1'b1; end
            default: w_acc_nxt = r_acc;
        endcase
        if (w_zs_upd) begin
            w_z_nxt = (w_acc_nxt == 8'h00);
            w_s_nxt = w_acc_nxt[7];
        end else begin
            w_z_nxt = z_flag;
            w_s_nxt = s_flag;
        end
    end

    // Memory: program load during reset, STA writes while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[r_lp] <= myprogram;
        end else if (w_mem_we && !HLT) begin
            r_mem[w_addr] <= r_acc;
        end
    end

    // CPU registers, load pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= 8'h00;
            r_pc     <= '0;
            r_lp     <= r_lp + n'(1);
            myoutput <= 8'h00;
            HLT      <= 1'b0;
            s_flag   <= 1'b0;
            z_flag   <= 1'b0;
            c_flag   <= 1'b0;
        end else begin
            // Load pointer rewinds whenever reset is low so each pulse starts at 0.
            r_lp <= '0;
            if (!HLT) begin
                r_acc  <= w_acc_nxt;
                r_pc   <= w_pc_nxt;
                HLT    <= w_halt_nxt;
                s_flag <= w_s_nxt;
                z_flag <= w_z_nxt;
                c_flag <= w_c_nxt;
                if (w_out_we) myoutput <= r_acc;
            end
        end
    end

endmodule

// File: tb/tb_four_bit_cpu.sv
// -----------------------------------------------------------------------------
// tb_four_bit_cpu
// Directed programs plus randomized programs, every cycle compared against a
// behavioural model of the instruction set held in the bench.
// -----------------------------------------------------------------------------
module tb_four_bit_cpu;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] myprogram = 8'h00;
    logic [7:0] myinput = 8'h00;
    logic [7:0] myoutput;
    logic       HLT, s_flag, z_flag, c_flag;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // reference model state
    int m_mem [16];
    int m_a, m_pc, m_lp, m_out;
    bit m_hlt, m_s, m_z, m_c;

    four_bit_cpu #(.n(4)) dut (
        .clk(clk), .rst(rst), .myprogram(myprogram), .myinput(myinput),
        .myoutput(myoutput), .HLT(HLT), .s_flag(s_flag), .z_flag(z_flag),
        .c_flag(c_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the instruction-set semantics, using pre-edge inputs.
    task automatic model_step(input bit r, input int prog, input int inp);
        int ins, op, k, v, res;
        if (r) begin
            m_mem[m_lp] = prog;
            m_lp = (m_lp + 1) % 16;
            m_a = 0; m_pc = 0; m_out = 0; m_hlt = 0;
            m_s = 0; m_z = 0; m_c = 0;
            return;
        end
        m_lp = 0;
        if (m_hlt) return;
        ins = m_mem[m_pc];
        op  = ins / 16;
        k   = ins % 16;
        v   = m_mem[k];
        res = m_a;
        case (op)
            1: res = v;
            2: res = k;
            3: begin res = m_a + v; m_c = (res > 255); res = res % 256; end
            4: begin m_c = (m_a < v); res = (m_a - v + 256) % 256; end
            5: begin res = m_a & v; m_c = 0; end
            6: begin res = m_a | v; m_c = 0; end
            7: begin res = m_a ^ v; m_c = 0; end
            8: m_mem[k] = m_a;
            9: res = inp;
            10: m_out = m_a;
            default: ;
        endcase
        if (op inside {1, 2, 3, 4, 5, 6, 7, 9}) begin
            m_z = (res == 0);
            m_s = (res >= 128);
        end
        m_a = res;
        case (op)
            11: m_pc = k;
            12: m_pc = m_z_prev_jump(m_z, k);
            13: m_pc = m_z_prev_jump(m_c, k);
            14: m_pc = m_z_prev_jump(m_s, k);
            15: m_hlt = 1;
            default: m_pc = (m_pc + 1) % 16;
        endcase
    endtask

    // Jump target selection: flags are unchanged by jumps, so current model
    // flags are the pre-edge flags.
    function automatic int m_z_prev_jump(input bit flag, input int k);
        return flag ? k : (m_pc + 1) % 16;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_out"}, myoutput, 8'(m_out));
        chk({tag, "_hlt"}, {7'h00, HLT}, {7'h00, m_hlt});
        chk({tag, "_s"}, {7'h00, s_flag}, {7'h00, m_s});
        chk({tag, "_z"}, {7'h00, z_flag}, {7'h00, m_z});
        chk({tag, "_c"}, {7'h00, c_flag}, {7'h00, m_c});
        chk({tag, "_pc"}, {4'h0, dut.r_pc}, 8'(m_pc));
        chk({tag, "_acc"}, dut.r_acc, 8'(m_a));
    endtask

    task automatic cyc(input bit r, input logic [7:0] prog, input logic [7:0] inp, input string tag);
        rst = r; myprogram = prog; myinput = inp;
        model_step(r, int'(prog), int'(inp));
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic load(input logic [7:0] words [$], input string tag);
        foreach (words[i]) cyc(1'b1, words[i], 8'h00, tag);
    endtask

    task automatic run(input int cycles, input logic [7:0] inp, input string tag);
        for (int i = 0; i < cycles; i++) cyc(1'b0, 8'h00, inp, tag);
    endtask

    initial begin
        logic [7:0] prg [$];
        logic [7:0] so_out;
        logic       so_s, so_z, so_c;
        logic [3:0] so_pc;
        logic [7:0] so_acc;

        // One cycle with rst low rewinds the load pointer to 0.
        m_lp = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Fill the whole memory with NOPs so nothing executes undefined words.
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h00, 8'h00, "clr");
        chk("reset_out", myoutput, 8'h00);
        chk("reset_hlt", {7'h00, HLT}, 8'h00);
        chk("reset_flags", {5'h00, s_flag, z_flag, c_flag}, 8'h00);

        // LDI 5; ADD M[3]; OUT; HLT
        prg = '{8'h25, 8'h33, 8'hA0, 8'hF0, 8'h00, 8'h07};
        load(prg, "ld1");
        run(4, 8'h00, "p1");
        chk("p1_hlt_const", {7'h00, HLT}, 8'h01);
        chk("p1_pc_const", {4'h0, dut.r_pc}, 8'h03);
        chk("p1_out_const", myoutput, 8'hF5);

        // IN; OUT; HLT with a negative input
        prg = '{8'h90, 8'hA0, 8'hF0};
        load(prg, "ld2");
        run(3, 8'h80, "p2");
        chk("p2_out_const", myoutput, 8'h80);
        chk("p2_s_const", {7'h00, s_flag}, 8'h01);
        chk("p2_z_const", {7'h00, z_flag}, 8'h00);
        chk("p2_hlt_const", {7'h00, HLT}, 8'h01);

        // 0x0F + 0xF1 wraps to zero with carry; JC taken to address 5
        prg = '{8'h2F, 8'h34, 8'hD5, 8'hA0, 8'hF1, 8'hA0, 8'hF0};
        load(prg, "ld3");
        run(3, 8'h00, "p3");
        chk("p3_pc_jump", {4'h0, dut.r_pc}, 8'h05);
        run(2, 8'h00, "p3b");
        chk("p3_acc_const", dut.r_acc, 8'h00);
        chk("p3_zc_const", {6'h00, z_flag, c_flag}, 8'h03);
        chk("p3_out_const", myoutput, 8'h00);
        chk("p3_hlt_const", {7'h00, HLT}, 8'h01);

        // 3 - 5 borrows
        prg = '{8'h23, 8'h44, 8'hF0, 8'h00, 8'h05};
        load(prg, "ld4");
        run(3, 8'h00, "p4");
        chk("p4_acc_const", dut.r_acc, 8'hFE);
        chk("p4_szc_const", {5'h00, s_flag, z_flag, c_flag}, 8'h05);
        chk("p4_hlt_const", {7'h00, HLT}, 8'h01);

        // Endless loop, then a one-cycle reset patches M[0] to HLT
        prg = '{8'h21, 8'hB0};
        load(prg, "ld5");
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 8'h00, 8'h00, "p5");
            chk("p5_pc_alt", {4'h0, dut.r_pc}, (i % 2 == 0) ? 8'h01 : 8'h00);
        end
        chk("p5_hlt_const", {7'h00, HLT}, 8'h00);
        cyc(1'b1, 8'hF0, 8'h00, "p5r");
        chk("p5_mem0", dut.r_mem[0], 8'hF0);
        chk("p5_cleared", {myoutput[6:0], HLT}, 8'h00);
        run(1, 8'h00, "p5h");
        chk("p5_hlt_after", {7'h00, HLT}, 8'h01);

        // Halted machine ignores inputs
        so_out = myoutput; so_s = s_flag; so_z = z_flag; so_c = c_flag;
        so_pc = dut.r_pc; so_acc = dut.r_acc;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 8'h00, 8'($urandom), "p6");
            chk("p6_frozen", {so_out ^ myoutput}, 8'h00);
        end
        chk("p6_frozen_regs", {so_acc ^ dut.r_acc}, 8'h00);
        chk("p6_frozen_flags", {4'h0, so_pc ^ dut.r_pc, 1'b0, so_s ^ s_flag, so_z ^ z_flag, so_c ^ c_flag} & 8'hF7, 8'h00);

        // Randomized programs with occasional mid-run reset pulses
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 16; i++) begin
                logic [7:0] w;
                w = 8'($urandom);
                if (w[7:4] == 4'hF && $urandom_range(0, 1) == 0) w[7:4] = 4'($urandom_range(0, 14));
                cyc(1'b1, w, 8'h00, "rld");
            end
            for (int i = 0; i < 40; i++) begin
                cyc(($urandom_range(0, 29) == 0), 8'($urandom), 8'($urandom), "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
